// File: rtl/nic_pkg.sv
// nic_pkg: shared constants for the memory-mapped network interface controller.
package nic_pkg;

    localparam int unsigned NIC_DATA_WIDTH = 64;
    localparam int unsigned NIC_ADDR_WIDTH = 2;

    // Register-select map seen by the processor's data-memory port
    localparam logic [1:0] NIC_ADDR_IN_BUF   = 2'd0;
    localparam logic [1:0] NIC_ADDR_IN_STAT  = 2'd1;
    localparam logic [1:0] NIC_ADDR_OUT_BUF  = 2'd2;
    localparam logic [1:0] NIC_ADDR_OUT_STAT = 2'd3;

    // Virtual-channel bit of an outgoing packet
    localparam int unsigned NIC_VC_BIT = 63;

endpackage

// File: rtl/nic_if.sv
// nic_if: processor dmem-slot signals plus the ring-router port of the NIC.
// master = processor/router side, slave = the NIC itself.
interface nic_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 2
);
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] d_in;
    logic [DATA_WIDTH-1:0] d_out;
    logic                  nicEn;
    logic                  nicWrEn;
    logic                  net_si;
    logic                  net_ri;
    logic [DATA_WIDTH-1:0] net_di;
    logic                  net_so;
    logic                  net_ro;
    logic [DATA_WIDTH-1:0] net_do;
    logic                  net_polarity;

    modport master (
        output addr, d_in, nicEn, nicWrEn, net_si, net_di, net_ro, net_polarity,
        input  d_out, net_ri, net_so, net_do
    );

    modport slave (
        input  addr, d_in, nicEn, nicWrEn, net_si, net_di, net_ro, net_polarity,
        output d_out, net_ri, net_so, net_do
    );
endinterface

// File: rtl/nic_channel_buf.sv
// nic_channel_buf: one-entry packet buffer with a full flag.
// A write is accepted only while empty; an accepted write wins over a same-cycle read.
module nic_channel_buf #(
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full
);
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_full;

    // Fill on write-while-empty, drain on read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
            r_full <= 1'b0;
        end else begin
            if (wr && !r_full) begin
                r_data <= data_in;
                r_full <= 1'b1;
            end else if (rd) begin
                r_full <= 1'b0;
            end
        end
    end

    assign data_out = r_data;
    assign full     = r_full;
endmodule

// File: rtl/nic.sv
// nic: memory-mapped NIC between the processor dmem port and one ring-router port.
// Optional feature macro: NIC_POLARITY_CHECK_EN (send only when packet VC bit matches
// the router's net_polarity). Undefined by default: packets send whenever net_ro is high.
module nic
    import nic_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = NIC_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = NIC_ADDR_WIDTH
) (
    input logic  clk,
    input logic  rst,
    nic_if.slave bus
);
    logic                  w_load;
    logic                  w_store;
    logic                  w_in_wr;
    logic                  w_in_rd;
    logic                  w_in_full;
    logic [DATA_WIDTH-1:0] w_in_data;
    logic                  w_out_wr;
    logic                  w_out_full;
    logic [DATA_WIDTH-1:0] w_out_data;
    logic                  w_send_ok;
    logic                  w_send;
    logic [DATA_WIDTH-1:0] w_rd_data;

    logic [DATA_WIDTH-1:0] r_d_out;
    logic                  r_net_so;
    logic [DATA_WIDTH-1:0] r_net_do;

    assign w_load   = bus.nicEn & ~bus.nicWrEn;
    assign w_store  = bus.nicEn & bus.nicWrEn;
    assign w_in_wr  = bus.net_si & ~w_in_full;
    assign w_in_rd  = w_load && (bus.addr == NIC_ADDR_IN_BUF);
    assign w_out_wr = w_store && (bus.addr == NIC_ADDR_OUT_BUF);

`ifdef NIC_POLARITY_CHECK_EN
    assign w_send_ok = (w_out_data[NIC_VC_BIT] == bus.net_polarity);
`else
    logic w_unused_polarity;
    assign w_unused_polarity = bus.net_polarity;
    assign w_send_ok         = 1'b1;
`endif

    assign w_send = w_out_full & bus.net_ro & w_send_ok;

    nic_channel_buf #(.DATA_WIDTH(DATA_WIDTH)) u_in_buf (
        .clk      (clk),
        .rst      (rst),
        .wr       (w_in_wr),
        .data_in  (bus.net_di),
        .rd       (w_in_rd),
        .data_out (w_in_data),
        .full     (w_in_full)
    );

    // Store to a full output buffer is dropped inside the buffer itself
    nic_channel_buf #(.DATA_WIDTH(DATA_WIDTH)) u_out_buf (
        .clk      (clk),
        .rst      (rst),
        .wr       (w_out_wr),
        .data_in  (bus.d_in),
        .rd       (w_send),
        .data_out (w_out_data),
        .full     (w_out_full)
    );

    // Register-select read mux; status words are zero-extended flags
    always_comb begin
        w_rd_data = '0;
        case (bus.addr)
            NIC_ADDR_IN_BUF:   w_rd_data = w_in_data;
            NIC_ADDR_IN_STAT:  w_rd_data = {{(DATA_WIDTH-1){1'b0}}, w_in_full};
            NIC_ADDR_OUT_BUF:  w_rd_data = w_out_data;
            NIC_ADDR_OUT_STAT: w_rd_data = {{(DATA_WIDTH-1){1'b0}}, w_out_full};
            default:           w_rd_data = '0;
        endcase
    end

    // Load data register: updates only on a load, otherwise holds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d_out <= '0;
        end else if (w_load) begin
            r_d_out <= w_rd_data;
        end
    end

    // Outbound registers: one-cycle valid pulse, data held between sends
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_net_so <= 1'b0;
            r_net_do <= '0;
        end else begin
            r_net_so <= w_send;
            if (w_send) begin
                r_net_do <= w_out_data;
            end
        end
    end

    assign bus.d_out  = r_d_out;
    assign bus.net_so = r_net_so;
    assign bus.net_do = r_net_do;
    assign bus.net_ri = ~w_in_full;
endmodule

// File: tb/tb_nic.sv
// tb_nic: directed + randomized bench for nic against a behavioural reference model.
module tb_nic;
    import nic_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    nic_if #(.DATA_WIDTH(64), .ADDR_WIDTH(2)) bus ();

    nic dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: what the processor/router should observe
    logic [63:0] m_in_buf, m_out_buf, m_dout, m_do;
    logic        m_in_full, m_out_full, m_so;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_in_buf   = '0;
        m_out_buf  = '0;
        m_dout     = '0;
        m_do       = '0;
        m_in_full  = 1'b0;
        m_out_full = 1'b0;
        m_so       = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".d_out"},  bus.d_out,         m_dout);
        check({tag, ".net_so"}, 64'(bus.net_so),   64'(m_so));
        check({tag, ".net_do"}, bus.net_do,        m_do);
        check({tag, ".net_ri"}, 64'(bus.net_ri),   64'(!m_in_full));
    endtask

    // One clock of stimulus: drive at negedge, advance the model, compare after posedge
    task automatic step(input string tag, input logic [1:0] a, input logic [63:0] d,
                        input logic en, input logic wr, input logic si,
                        input logic [63:0] di, input logic ro, input logic pol);
        logic [63:0] rd_val;
        logic        send, capture, consume, store_ok, load;
        @(negedge clk);
        bus.addr         = a;
        bus.d_in         = d;
        bus.nicEn        = en;
        bus.nicWrEn      = wr;
        bus.net_si       = si;
        bus.net_di       = di;
        bus.net_ro       = ro;
        bus.net_polarity = pol;

        case (a)
            2'd0:    rd_val = m_in_buf;
            2'd1:    rd_val = {63'b0, m_in_full};
            2'd2:    rd_val = m_out_buf;
            default: rd_val = {63'b0, m_out_full};
        endcase
`ifdef NIC_POLARITY_CHECK_EN
        send = m_out_full && ro && (m_out_buf[63] == pol);
`else
        send = m_out_full && ro;
`endif
        load     = en && !wr;
        capture  = si && !m_in_full;
        consume  = load && (a == 2'd0);
        store_ok = en && wr && (a == 2'd2) && !m_out_full;

        if (load) m_dout = rd_val;
        m_so = send;
        if (send) m_do = m_out_buf;
        if (capture) begin
            m_in_buf  = di;
            m_in_full = 1'b1;
        end else if (consume) begin
            m_in_full = 1'b0;
        end
        if (store_ok) begin
            m_out_buf  = d;
            m_out_full = 1'b1;
        end else if (send) begin
            m_out_full = 1'b0;
        end

        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic idle(input logic ro);
        step("idle", 2'd0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0, ro, 1'b0);
    endtask

    initial begin
        bus.addr = '0; bus.d_in = '0; bus.nicEn = 1'b0; bus.nicWrEn = 1'b0;
        bus.net_si = 1'b0; bus.net_di = '0; bus.net_ro = 1'b0; bus.net_polarity = 1'b0;
        model_reset();
        rst = 1'b1;
        #1;
        check("rst.d_out",  bus.d_out,          64'h0);
        check("rst.net_so", 64'(bus.net_so),    64'h0);
        check("rst.net_do", bus.net_do,         64'h0);
        check("rst.net_ri", 64'(bus.net_ri),    64'h1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Output channel basic send
        step("ld_ostat", 2'd3, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
        check("ld_ostat0", bus.d_out, 64'h0);
        step("st_a5", 2'd2, 64'hA5, 1'b1, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0);
        check("st_a5.no_same_cycle", 64'(bus.net_so), 64'h0);
        idle(1'b1);
        check("send_a5.so", 64'(bus.net_so), 64'h1);
        check("send_a5.do", bus.net_do, 64'hA5);
        step("ld_ostat2", 2'd3, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
        check("pulse_one_cycle", 64'(bus.net_so), 64'h0);
        check("ostat_empty", bus.d_out, 64'h0);

        // Second store to a full, blocked buffer is dropped
        step("st_1", 2'd2, 64'h1, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
        step("st_2", 2'd2, 64'h2, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
        step("ld_obuf", 2'd2, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
        check("obuf_kept", bus.d_out, 64'h1);
        idle(1'b1);
        check("send_1.so", 64'(bus.net_so), 64'h1);
        check("send_1.do", bus.net_do, 64'h1);
        idle(1'b0);

        // Inbound capture, hold-off while full, then consume
        step("si_beef", 2'd0, 64'h0, 1'b0, 1'b0, 1'b1, 64'hBEEF, 1'b0, 1'b0);
        check("beef.ri_low", 64'(bus.net_ri), 64'h0);
        step("ld_istat", 2'd1, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
        check("istat_full", bus.d_out, 64'h1);
        step("si_while_full", 2'd0, 64'h0, 1'b0, 1'b0, 1'b1, 64'h1234, 1'b0, 1'b0);
        step("ld_ibuf", 2'd0, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
        check("ibuf_beef", bus.d_out, 64'hBEEF);
        check("ibuf.ri_high", 64'(bus.net_ri), 64'h1);

        // Load addr 0 with simultaneous capture returns stale data and refills
        step("ld_and_si", 2'd0, 64'h0, 1'b1, 1'b0, 1'b1, 64'h5555, 1'b0, 1'b0);
        check("stale_ibuf", bus.d_out, 64'hBEEF);
        check("refilled.ri", 64'(bus.net_ri), 64'h0);
        step("ld_ibuf2", 2'd0, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
        check("ibuf_5555", bus.d_out, 64'h5555);

`ifdef NIC_POLARITY_CHECK_EN
        step("st_vc1", 2'd2, 64'h8000_0000_0000_0001, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
        step("pol0", 2'd0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
        check("vc1_wait", 64'(bus.net_so), 64'h0);
        step("pol1", 2'd0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1);
        check("vc1_sent", 64'(bus.net_so), 64'h1);
        check("vc1_do", bus.net_do, 64'h8000_0000_0000_0001);
        idle(1'b0);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            logic [63:0] rd_d, rd_di;
            rd_d  = {$urandom, $urandom};
            rd_di = {$urandom, $urandom};
            step("rand", 2'($urandom_range(0, 3)), rd_d, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rd_di,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        idle(1'b0);

        // Mid-operation reset with both buffers full
        step("pre_st", 2'd2, 64'h0000_0000_0000_0077, 1'b1, 1'b1, 1'b1, 64'h99, 1'b0, 1'b0);
        step("pre_ld", 2'd1, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
        check("pre_rst.d_out", bus.d_out, 64'h1);
        #2;
        rst = 1'b1;
        bus.nicEn = 1'b0;
        bus.net_si = 1'b0;
        #1;
        model_reset();
        check("mid_rst.d_out",  bus.d_out,        64'h0);
        check("mid_rst.net_so", 64'(bus.net_so),  64'h0);
        check("mid_rst.net_ri", 64'(bus.net_ri),  64'h1);
        check("mid_rst.net_do", bus.net_do,       64'h0);
        @(negedge clk);
        rst = 1'b0;
        step("post_ostat", 2'd3, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
        check("post_rst.out_full", bus.d_out, 64'h0);
        step("post_istat", 2'd1, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
        check("post_rst.in_full", bus.d_out, 64'h0);
        check("post_rst.no_send", 64'(bus.net_so), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
